// File: rtl/ntru_pkg.sv
// Shared NTRU definitions: polynomial length, ternary coefficient codes and streamer states.
package ntru_pkg;

  localparam int unsigned NUM_N = 701;

  localparam logic [1:0] COEF_ZERO = 2'b00;
  localparam logic [1:0] COEF_POS  = 2'b01;
  localparam logic [1:0] COEF_NEG  = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StStream,
    StDrain,
    StDone
  } streamer_state_t;

endpackage

// File: rtl/coeff_shift_reg.sv
// Parallel-load coefficient register; shifts toward the top so head is always the next
// coefficient to emit (highest index first).
module coeff_shift_reg #(
  parameter int unsigned NUM_N = 701
) (
  input  logic               clk,
  input  logic               load,
  input  logic               shift,
  input  logic [2*NUM_N-1:0] din,
  output logic [1:0]         head
);

  logic [2*NUM_N-1:0] data_q;

  always_ff @(posedge clk) begin
    if (load) begin
      data_q <= din;
    end else if (shift) begin
      data_q <= {data_q[2*NUM_N-3:0], 2'b00};
    end
  end

  assign head = data_q[2*NUM_N-1 -: 2];

endmodule

// File: rtl/ternary_coeff_streamer.sv
// Streams a latched ternary polynomial to the multiplier, one 2-bit coefficient per cycle,
// highest index first, with an init pulse before and a drain cycle after.
module ternary_coeff_streamer #(
  parameter int unsigned NUM_N = ntru_pkg::NUM_N,
  parameter int unsigned CNT_W = $clog2(NUM_N + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [2*NUM_N-1:0] poly_in,
  output logic               busy,
  output logic               mul_en,
  output logic [1:0]         rin,
  output logic               done,
  output logic               err,
  output logic [CNT_W-1:0]   weight
);
  import ntru_pkg::*;

  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NUM_N - 1);

  streamer_state_t state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] weight_q, weight_d;
  logic             err_q, err_d;
  logic [1:0]       rin_q, rin_d;
  logic             busy_q, mul_en_q, done_q;
  logic             load, shift, emit;
  logic [1:0]       head;

  coeff_shift_reg #(
    .NUM_N(NUM_N)
  ) u_shift_reg (
    .clk  (clk),
    .load (load),
    .shift(shift),
    .din  (poly_in),
    .head (head)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    weight_d = weight_q;
    err_d    = err_q;
    rin_d    = COEF_ZERO;
    load     = 1'b0;
    shift    = 1'b0;
    emit     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d  = StArm;
          load     = 1'b1;
          cnt_d    = '0;
          weight_d = '0;
          err_d    = 1'b0;
        end
      end
      StArm: begin
        state_d = StStream;
        emit    = 1'b1;
      end
      StStream: begin
        cnt_d = cnt_q + CNT_W'(1);
        // The coefficient for the next STREAM cycle is emitted at this edge.
        if (cnt_q == LastCnt) begin
          state_d = StDrain;
        end else begin
          emit = 1'b1;
        end
      end
      StDrain: state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (abort && (state_q inside {StArm, StStream, StDrain})) begin
      state_d = StIdle;
      emit    = 1'b0;
    end

    if (emit) begin
      shift = 1'b1;
      case (head)
        COEF_POS, COEF_NEG: begin
          rin_d    = head;
          weight_d = weight_q + CNT_W'(1);
        end
        COEF_ZERO: rin_d = COEF_ZERO;
        default:   err_d = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      weight_q <= '0;
      err_q    <= 1'b0;
      rin_q    <= COEF_ZERO;
      busy_q   <= 1'b0;
      mul_en_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      weight_q <= weight_d;
      err_q    <= err_d;
      rin_q    <= rin_d;
      busy_q   <= (state_d != StIdle);
      mul_en_q <= (state_d == StArm);
      done_q   <= (state_d == StDone);
    end
  end

  assign busy   = busy_q;
  assign mul_en = mul_en_q;
  assign rin    = rin_q;
  assign done   = done_q;
  assign err    = err_q;
  assign weight = weight_q;

endmodule

// File: tb/tb_ternary_coeff_streamer.sv
// Randomized self-checking bench for ternary_coeff_streamer against a list-level model.
module tb_ternary_coeff_streamer;

  localparam int N = 701;
  localparam int CW = $clog2(N + 1);

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           abort = 1'b0;
  logic [2*N-1:0] poly_in = '0;
  logic           busy, mul_en, done, err;
  logic [1:0]     rin;
  logic [CW-1:0]  weight;

  int checks = 0;
  int failures = 0;

  ternary_coeff_streamer #(
    .NUM_N(N)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .abort  (abort),
    .poly_in(poly_in),
    .busy   (busy),
    .mul_en (mul_en),
    .rin    (rin),
    .done   (done),
    .err    (err),
    .weight (weight)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] coef_at(input logic [2*N-1:0] p, input int idx);
    return p[2*idx +: 2];
  endfunction

  // inv_pct: percentage chance that a slot holds the invalid code 2'b10.
  function automatic logic [2*N-1:0] rand_poly(input int inv_pct);
    logic [2*N-1:0] p;
    logic [1:0] codes[3];
    codes[0] = 2'b00;
    codes[1] = 2'b01;
    codes[2] = 2'b11;
    for (int k = 0; k < N; k++) begin
      if ($urandom_range(0, 99) < inv_pct) p[2*k +: 2] = 2'b10;
      else p[2*k +: 2] = codes[$urandom_range(0, 2)];
    end
    return p;
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_mul_en"}, mul_en, 0);
    check({tag, "_rin"}, rin, 0);
    check({tag, "_done"}, done, 0);
  endtask

  // intr_mode: 0 none, 1 abort, 2 reset; raised during cycle T+2+intr_k.
  // poke_k: stream slot at which a stray start (with changed poly_in) is pulsed, -1 for none.
  task automatic run_transfer(input logic [2*N-1:0] p, input int intr_mode, input int intr_k,
                              input int poke_k);
    logic [1:0] exp_rin;
    int exp_weight;
    int exp_err;
    exp_weight = 0;
    exp_err = 0;
    for (int i = 0; i < N; i++) begin
      if (coef_at(p, i) == 2'b10) exp_err = 1;
      else if (coef_at(p, i) != 2'b00) exp_weight++;
    end

    @(negedge clk);
    start = 1'b1;
    poly_in = p;
    @(negedge clk);  // cycle T+1
    start = 1'b0;
    poly_in = ~p;
    check("arm_mul_en", mul_en, 1);
    check("arm_busy", busy, 1);
    check("arm_rin", rin, 0);

    for (int k = 0; k < N; k++) begin
      @(negedge clk);  // cycle T+2+k
      start = 1'b0;
      exp_rin = coef_at(p, N - 1 - k);
      if (exp_rin == 2'b10) exp_rin = 2'b00;
      check("stream_rin", rin, exp_rin);
      if (k == 0 || k == N - 1) begin
        check("stream_busy", busy, 1);
        check("stream_mul_en", mul_en, 0);
        check("stream_done", done, 0);
      end
      if (k == poke_k) begin
        start = 1'b1;
        poly_in = rand_poly(0);
      end
      if (intr_mode != 0 && k == intr_k) begin
        if (intr_mode == 1) abort = 1'b1;
        else rst = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        rst = 1'b0;
        start = 1'b0;
        check_idle_outputs(intr_mode == 1 ? "abort" : "midrst");
        if (intr_mode == 2) begin
          check("midrst_err", err, 0);
          check("midrst_weight", weight, 0);
        end
        for (int j = 0; j < 10; j++) begin
          @(negedge clk);
          check("intr_no_done", done, 0);
          check("intr_busy", busy, 0);
        end
        return;
      end
    end

    @(negedge clk);  // DRAIN, T+N+2
    check("drain_rin", rin, 0);
    check("drain_done", done, 0);
    check("drain_busy", busy, 1);
    @(negedge clk);  // DONE, T+N+3
    check("done_pulse", done, 1);
    check("done_busy", busy, 1);
    check("done_weight", weight, exp_weight);
    check("done_err", err, exp_err);
    start = 1'b1;
    poly_in = rand_poly(0);
    @(negedge clk);
    start = 1'b0;
    check_idle_outputs("post_done");
    check("hold_weight", weight, exp_weight);
    check("hold_err", err, exp_err);
    @(negedge clk);
    check("post_done_mul_en", mul_en, 0);
    check("post_done_busy", busy, 0);
  endtask

  initial begin
    logic [2*N-1:0] p;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check_idle_outputs("reset");
    check("reset_err", err, 0);
    check("reset_weight", weight, 0);
    repeat (3) @(negedge clk);
    check("reset_busy_stays", busy, 0);

    // All +1 except coefficient N-1 = -1.
    for (int k = 0; k < N; k++) p[2*k +: 2] = 2'b01;
    p[2*(N-1) +: 2] = 2'b11;
    run_transfer(p, 0, 0, -1);

    // Invalid code in slot 3 on an otherwise random valid polynomial.
    p = rand_poly(0);
    p[2*3 +: 2] = 2'b10;
    run_transfer(p, 0, 0, -1);

    // Random with sprinkled invalids and a stray start mid-stream.
    run_transfer(rand_poly(5), 0, 0, 10);

    // Abort at T+50, then a fresh transfer must restart with a new mul_en.
    run_transfer(rand_poly(2), 1, 48, -1);
    run_transfer(rand_poly(0), 0, 0, -1);

    // Synchronous reset at T+100 overriding start.
    run_transfer(rand_poly(3), 2, 98, -1);

    // All-zero polynomial: weight 0, no error.
    run_transfer('0, 0, 0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
